kogge_share_arb: RTL and testbench

//  Round-robin scheduler sharing one kogge prefix adder among NREQ requesters.

---
 rtl/kogge_share_pkg.sv | 24 ++
 rtl/kogge_adder.sv | 39 +++
 rtl/kogge_rr_arb.sv | 37 +++
 rtl/kogge_share_arb.sv | 104 ++++++++++
 tb/tb_kogge_share_arb.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/kogge_share_pkg.sv
// Shared definitions for the round-robin shared Kogge-Stone adder block:
// ID width derivation, signed-overflow rule and parameter legality checks.
package kogge_share_pkg;

   localparam int MIN_WIDTH = 2;

   function automatic int id_width(input int nreq);
      return (nreq > 1) ? $clog2(nreq) : 1;
   endfunction

   function automatic bit is_pow2(input int w);
      return (w > 0) && ((w & (w - 1)) == 0);
   endfunction

   function automatic bit width_ok(input int w);
      return is_pow2(w) && (w >= MIN_WIDTH);
   endfunction

   // Same-sign operands producing an opposite-sign result means the sum wrapped.
   function automatic logic sovf(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/kogge_adder.sv
// Kogge-Stone parallel-prefix adder, sum modulo 2^WIDTH, no carry in/out.
// Prefix depth is $clog2(WIDTH) levels of (generate, propagate) combining.
module kogge_adder #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_sum
);

   localparam int LOG = $clog2(WIDTH);

   logic [WIDTH-1:0] w_g;
   logic [WIDTH-1:0] w_p;
   logic [WIDTH-1:0] w_gn;
   logic [WIDTH-1:0] w_pn;
   logic [WIDTH-1:0] w_p0;

   always_comb begin
      w_g  = i_a & i_b;
      w_p  = i_a ^ i_b;
      w_p0 = w_p;
      w_gn = w_g;
      w_pn = w_p;
      for (int k = 0; k < LOG; k++) begin
         w_gn = w_g;
         w_pn = w_p;
         for (int i = (1 << k); i < WIDTH; i++) begin
            w_gn[i] = w_g[i] | (w_p[i] & w_g[i - (1 << k)]);
            w_pn[i] = w_p[i] & w_p[i - (1 << k)];
         end
         w_g = w_gn;
         w_p = w_pn;
      end
      // After the last level w_g[i] is the carry out of bits [i:0].
      o_sum = w_p0 ^ {w_g[WIDTH-2:0], 1'b0};
   end

endmodule

// File: rtl/kogge_rr_arb.sv
// Round-robin arbiter: picks the first valid requester scanning upward from
// i_rr_ptr (mod NREQ); the grant is one-hot and gated by i_en.
module kogge_rr_arb
   import kogge_share_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int ID_W = id_width(NREQ)
) (
   input  logic [NREQ-1:0] i_req_valid,
   input  logic [ID_W-1:0] i_rr_ptr,
   input  logic            i_en,
   output logic [NREQ-1:0] o_grant,
   output logic [ID_W-1:0] o_winner,
   output logic            o_any
);

   logic [ID_W-1:0] w_idx;

   // Scan in reverse priority so the last hit is the highest-priority requester.
   always_comb begin
      o_any    = 1'b0;
      o_winner = '0;
      w_idx    = '0;
      for (int off = NREQ - 1; off >= 0; off--) begin
         w_idx = ID_W'((int'(i_rr_ptr) + off) % NREQ);
         if (i_req_valid[w_idx]) begin
            o_any    = 1'b1;
            o_winner = w_idx;
         end
      end
      o_grant = '0;
      if (i_en && o_any) begin
         o_grant[o_winner] = 1'b1;
      end
   end

endmodule

// File: rtl/kogge_share_arb.sv
// Round-robin scheduler sharing one Kogge-Stone adder among NREQ requesters:
// operand register (S0) -> shared adder -> result register (S1) with backpressure.
module kogge_share_arb
   import kogge_share_pkg::*;
#(
   parameter  int WIDTH = 16,
   parameter  int NREQ  = 4,
   localparam int ID_W  = id_width(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic [NREQ-1:0]       req_ready,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [ID_W-1:0]       rsp_id,
   output logic [WIDTH-1:0]      rsp_sum,
   output logic                  rsp_ovf
);

   if (!width_ok(WIDTH)) begin : g_bad_width
      $error("kogge_share_arb: WIDTH must be a power of two and at least 2");
   end

   logic [ID_W-1:0]         r_rr_ptr;
   logic                    r_vld_p0;
   logic signed [WIDTH-1:0] r_a_p0;
   logic signed [WIDTH-1:0] r_b_p0;
   logic [ID_W-1:0]         r_id_p0;
   logic                    r_vld_p1;
   logic signed [WIDTH-1:0] r_sum_p1;
   logic                    r_ovf_p1;
   logic [ID_W-1:0]         r_id_p1;

   logic                    w_adv0;
   logic                    w_adv1;
   logic                    w_any;
   logic [ID_W-1:0]         w_winner;
   logic [ID_W-1:0]         w_ptr_nxt;
   logic [WIDTH-1:0]        w_sum;

   assign w_adv1    = !r_vld_p1 || rsp_ready;
   assign w_adv0    = !r_vld_p0 || w_adv1;
   assign w_ptr_nxt = (w_winner == ID_W'(NREQ - 1)) ? '0 : w_winner + 1'b1;

   kogge_rr_arb #(
      .NREQ (NREQ)
   ) u_arb (
      .i_req_valid (req_valid),
      .i_rr_ptr    (r_rr_ptr),
      .i_en        (w_adv0 && !rst),
      .o_grant     (req_ready),
      .o_winner    (w_winner),
      .o_any       (w_any)
   );

   kogge_adder #(
      .WIDTH (WIDTH)
   ) u_adder (
      .i_a   (r_a_p0),
      .i_b   (r_b_p0),
      .o_sum (w_sum)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr <= '0;
         r_vld_p0 <= 1'b0;
         r_a_p0   <= '0;
         r_b_p0   <= '0;
         r_id_p0  <= '0;
         r_vld_p1 <= 1'b0;
         r_sum_p1 <= '0;
         r_ovf_p1 <= 1'b0;
         r_id_p1  <= '0;
      end else begin
         // S0 -> adder -> S1
         if (w_adv1) begin
            r_vld_p1 <= r_vld_p0;
            r_sum_p1 <= $signed(w_sum);
            r_ovf_p1 <= sovf(r_a_p0[WIDTH-1], r_b_p0[WIDTH-1], w_sum[WIDTH-1]);
            r_id_p1  <= r_id_p0;
         end
         // requesters -> S0
         if (w_adv0) begin
            r_vld_p0 <= w_any;
            r_a_p0   <= $signed(req_a[int'(w_winner) * WIDTH +: WIDTH]);
            r_b_p0   <= $signed(req_b[int'(w_winner) * WIDTH +: WIDTH]);
            r_id_p0  <= w_winner;
         end
         if (w_adv0 && w_any) begin
            r_rr_ptr <= w_ptr_nxt;
         end
      end
   end

   assign rsp_valid = r_vld_p1;
   assign rsp_id    = r_id_p1;
   assign rsp_sum   = r_sum_p1;
   assign rsp_ovf   = r_ovf_p1;

endmodule

// File: tb/tb_kogge_share_arb.sv
// Directed + random bench for kogge_share_arb against a queue-based reference
// of the round-robin grant order and the signed sums each requester should get.
module tb_kogge_share_arb;

   localparam int W = 16;
   localparam int N = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req_valid;
   logic [N*W-1:0]   req_a;
   logic [N*W-1:0]   req_b;
   logic [N-1:0]     req_ready;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [1:0]       rsp_id;
   logic [W-1:0]     rsp_sum;
   logic             rsp_ovf;

   always #5 clk = ~clk;

   kogge_share_arb #(
      .WIDTH (W),
      .NREQ  (N)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_ovf   (rsp_ovf)
   );

   typedef struct {
      int id;
      int sum;
      bit ovf;
      bit in_s1;
   } item_t;

   item_t q[$];
   item_t it;
   int    ptr   = 0;
   int    n_cmp = 0;
   int    n_mis = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_mis++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N*W-1:0] rnd_vec();
      return {$urandom, $urandom};
   endfunction

   // One clock cycle: drive inputs at the falling edge, check the grant, advance
   // the reference through the rising edge, then check the registered response.
   task automatic step(input bit r, input logic [N-1:0] v, input logic [N*W-1:0] a,
                       input logic [N*W-1:0] b, input bit rr, output logic [N-1:0] g);
      int          n;
      bit          s1f, s0f, adv1, adv0, exp_v;
      int          win, idx, s;
      shortint     sa, sb;
      logic [N-1:0] exp_g;
      rst       = r;
      req_valid = v;
      req_a     = a;
      req_b     = b;
      rsp_ready = rr;
      #1;
      n    = q.size();
      s1f  = (n > 0) && q[0].in_s1;
      s0f  = (n == 2) || ((n == 1) && !q[0].in_s1);
      adv1 = !s1f || rr;
      adv0 = !s0f || adv1;
      win  = -1;
      for (int off = 0; off < N; off++) begin
         idx = (ptr + off) % N;
         if (win < 0 && v[idx]) win = idx;
      end
      exp_g = '0;
      if (!r && adv0 && win >= 0) exp_g[win] = 1'b1;
      g = req_ready;
      check("req_ready", 32'(req_ready), 32'(exp_g));
      check("grant_onehot0", 32'($onehot0(req_ready)), 32'd1);
      check("grant_invalid", 32'(req_ready & ~v), 32'd0);
      if (r) begin
         q.delete();
         ptr = 0;
      end else begin
         if (s1f && rr) void'(q.pop_front());
         if (adv1 && q.size() > 0 && !q[0].in_s1) begin
            it       = q[0];
            it.in_s1 = 1'b1;
            q[0]     = it;
         end
         if (adv0 && win >= 0) begin
            sa       = shortint'(a[win*W +: W]);
            sb       = shortint'(b[win*W +: W]);
            s        = int'(sa) + int'(sb);
            it.id    = win;
            it.sum   = s & 32'hFFFF;
            it.ovf   = (s > 32767) || (s < -32768);
            it.in_s1 = 1'b0;
            q.push_back(it);
            ptr = (win + 1) % N;
         end
      end
      @(posedge clk);
      @(negedge clk);
      exp_v = (q.size() > 0) && q[0].in_s1;
      check("rsp_valid", 32'(rsp_valid), 32'(exp_v));
      if (exp_v) begin
         check("rsp_id", 32'(rsp_id), 32'(q[0].id));
         check("rsp_sum", 32'(rsp_sum), 32'(q[0].sum));
         check("rsp_ovf", 32'(rsp_ovf), 32'(q[0].ovf));
      end
   endtask

   initial begin
      logic [N-1:0]   g;
      logic [N*W-1:0] va;
      logic [N*W-1:0] vb;
      int             grants;

      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      @(negedge clk);

      // reset held with every requester asking
      step(1'b1, 4'hF, rnd_vec(), rnd_vec(), 1'b1, g);
      step(1'b1, 4'hF, rnd_vec(), rnd_vec(), 1'b1, g);
      check("reset_valid", 32'(rsp_valid), 32'd0);
      check("reset_sum", 32'(rsp_sum), 32'd0);
      check("reset_id", 32'(rsp_id), 32'd0);

      // single request on port 2
      va = '0; vb = '0;
      va[2*W +: W] = 16'h0005;
      vb[2*W +: W] = 16'h0003;
      step(1'b0, 4'b0100, va, vb, 1'b1, g);
      check("single_grant", 32'(g), 32'h4);
      step(1'b0, 4'b0000, va, vb, 1'b1, g);
      check("single_valid", 32'(rsp_valid), 32'd1);
      check("single_sum", 32'(rsp_sum), 32'h0008);
      check("single_id", 32'(rsp_id), 32'd2);
      check("single_ovf", 32'(rsp_ovf), 32'd0);

      // all requesters continuously valid, full throughput
      for (int i = 0; i < 12; i++) step(1'b0, 4'hF, rnd_vec(), rnd_vec(), 1'b1, g);
      for (int i = 0; i < 3; i++) step(1'b0, 4'h0, rnd_vec(), rnd_vec(), 1'b1, g);

      // overflow boundaries on port 0
      va = '0; vb = '0;
      va[W-1:0] = 16'h7FFF; vb[W-1:0] = 16'h0001;
      step(1'b0, 4'b0001, va, vb, 1'b1, g);
      step(1'b0, 4'b0000, va, vb, 1'b1, g);
      check("ovf_pos_sum", 32'(rsp_sum), 32'h8000);
      check("ovf_pos_flag", 32'(rsp_ovf), 32'd1);
      va[W-1:0] = 16'h8000; vb[W-1:0] = 16'hFFFF;
      step(1'b0, 4'b0001, va, vb, 1'b1, g);
      step(1'b0, 4'b0000, va, vb, 1'b1, g);
      check("ovf_neg_sum", 32'(rsp_sum), 32'h7FFF);
      check("ovf_neg_flag", 32'(rsp_ovf), 32'd1);
      va[W-1:0] = 16'hFFFF; vb[W-1:0] = 16'h0001;
      step(1'b0, 4'b0001, va, vb, 1'b1, g);
      step(1'b0, 4'b0000, va, vb, 1'b1, g);
      check("wrap_zero_sum", 32'(rsp_sum), 32'h0000);
      check("wrap_zero_flag", 32'(rsp_ovf), 32'd0);
      step(1'b0, 4'b0000, va, vb, 1'b1, g);

      // backpressure: only two operand sets fit before the pipe is full
      grants = 0;
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 4'hF, rnd_vec(), rnd_vec(), 1'b0, g);
         if (g != '0) grants++;
      end
      check("stall_grants", 32'(grants), 32'd2);
      for (int i = 0; i < 4; i++) step(1'b0, 4'h0, rnd_vec(), rnd_vec(), 1'b1, g);

      // reset with both stages full
      step(1'b0, 4'hF, rnd_vec(), rnd_vec(), 1'b0, g);
      step(1'b0, 4'hF, rnd_vec(), rnd_vec(), 1'b0, g);
      step(1'b1, 4'hF, rnd_vec(), rnd_vec(), 1'b0, g);
      check("midrst_valid", 32'(rsp_valid), 32'd0);
      step(1'b0, 4'b0110, rnd_vec(), rnd_vec(), 1'b1, g);
      check("midrst_first_grant", 32'(g), 32'h2);
      for (int i = 0; i < 3; i++) step(1'b0, 4'h0, rnd_vec(), rnd_vec(), 1'b1, g);

      // random traffic with random backpressure
      for (int i = 0; i < 300; i++) begin
         step(1'b0, 4'($urandom_range(0, 15)), rnd_vec(), rnd_vec(),
              ($urandom_range(0, 9) < 7), g);
      end
      for (int i = 0; i < 4; i++) step(1'b0, 4'h0, rnd_vec(), rnd_vec(), 1'b1, g);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
